// File: rtl/sprite_list_writer.sv
// sprite_list_writer: Avalon-MM slave holding a CPU-side shadow sprite list and
// a display-side active list. A software commit copies shadow to active on the
// first line of vertical blank so the sprite controller never sees a torn frame.
// Optional macro SPRITE_IRQ_EN adds an irq output raised after each commit.
module sprite_list_writer #(
  parameter int unsigned NUM_SPRITES = 20,
  parameter int unsigned VBLANK_LINE = 480,
  parameter int unsigned ENTRY_W     = 24
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  chipselect,
  input  logic                                  write,
  input  logic                                  read,
  input  logic [4:0]                            address,
  input  logic [31:0]                           writedata,
  output logic [31:0]                           readdata,
  input  logic [9:0]                            VGA_VCOUNT,
  output logic [NUM_SPRITES-1:0][ENTRY_W-1:0]   gl_array
`ifdef SPRITE_IRQ_EN
  ,
  output logic                                  irq
`endif
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned VC_W   = 10;
  localparam int unsigned FC_W   = 8;

  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_SPRITES);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_SPRITES + 1);

  typedef enum logic {
    S_IDLE,
    S_PENDING
  } state_e;

  state_e                                state_q, state_d;
  logic [ENTRY_W-1:0]                    shadow_q [NUM_SPRITES];
  logic [ENTRY_W-1:0]                    shadow_d [NUM_SPRITES];
  logic [NUM_SPRITES-1:0][ENTRY_W-1:0]   active_q, active_d;
  logic [FC_W-1:0]                       frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0]                     readdata_q, readdata_d;
  logic                                  vblank_q, vblank_d;
`ifdef SPRITE_IRQ_EN
  logic                                  irq_q, irq_d;
`endif

  logic vblank_c;
  logic vb_edge_c;
  logic wr_c;
  logic rd_c;
  logic commit_req_c;
  logic copy_c;
  logic pending_c;

  // Upper write-data bits beyond an entry carry no meaning.
  logic unused_wd_bits;
  assign unused_wd_bits = ^writedata[DATA_W-1:ENTRY_W];

  // Next-state: commit FSM, list copy, entry writes, register reads, irq.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    frame_cnt_d = frame_cnt_q;
    readdata_d  = readdata_q;
    copy_c      = 1'b0;

    vblank_c     = (VGA_VCOUNT >= VC_W'(VBLANK_LINE));
    vblank_d     = vblank_c;
    vb_edge_c    = vblank_c && !vblank_q;
    wr_c         = chipselect && write;
    rd_c         = chipselect && read;
    commit_req_c = wr_c && (address == CTRL_ADDR) && writedata[0];
    pending_c    = (state_q == S_PENDING);

    case (state_q)
      S_IDLE: begin
        if (commit_req_c) begin
          if (vb_edge_c) copy_c = 1'b1;
          else           state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        if (vb_edge_c) begin
          copy_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Copy samples the shadow as it stood before any same-cycle write.
    if (copy_c) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) active_d[i] = shadow_q[i];
      frame_cnt_d = frame_cnt_q + FC_W'(1);
    end

    if (wr_c) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        if (address == ADDR_W'(i)) shadow_d[i] = writedata[ENTRY_W-1:0];
      end
    end

    if (rd_c) begin
      readdata_d = '0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        if (address == ADDR_W'(i)) readdata_d = DATA_W'(shadow_q[i]);
      end
      if (address == STATUS_ADDR) readdata_d = {16'b0, frame_cnt_q, 7'b0, pending_c};
    end

`ifdef SPRITE_IRQ_EN
    irq_d = irq_q;
    if (rd_c && (address == STATUS_ADDR)) irq_d = 1'b0;
    if (copy_c)                           irq_d = 1'b1;
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) shadow_q[i] <= '0;
      active_q    <= '0;
      frame_cnt_q <= '0;
      readdata_q  <= '0;
      vblank_q    <= 1'b0;
`ifdef SPRITE_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      frame_cnt_q <= frame_cnt_d;
      readdata_q  <= readdata_d;
      vblank_q    <= vblank_d;
`ifdef SPRITE_IRQ_EN
      irq_q       <= irq_d;
`endif
    end
  end

  assign readdata = readdata_q;
  assign gl_array = active_q;
`ifdef SPRITE_IRQ_EN
  assign irq      = irq_q;
`endif

endmodule

// File: tb/tb_sprite_list_writer.sv
// Testbench for sprite_list_writer: directed scenarios plus random traffic,
// checked every cycle against a behavioural list/commit model.
module tb_sprite_list_writer;

  localparam int unsigned NS = 20;
  localparam int unsigned EW = 24;
  localparam int unsigned VB = 480;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    chipselect;
  logic                    write;
  logic                    read;
  logic [4:0]              address;
  logic [31:0]             writedata;
  logic [31:0]             readdata;
  logic [9:0]              vga_vcount;
  logic [NS-1:0][EW-1:0]   gl_array;
`ifdef SPRITE_IRQ_EN
  logic                    irq;
`endif

  always #5 clk = ~clk;

  sprite_list_writer #(.NUM_SPRITES(NS), .VBLANK_LINE(VB), .ENTRY_W(EW)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .VGA_VCOUNT (vga_vcount),
    .gl_array   (gl_array)
`ifdef SPRITE_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // Reference model state
  logic [EW-1:0]           m_sh [NS];
  logic [NS-1:0][EW-1:0]   m_act;
  bit                      m_pend;
  logic [7:0]              m_fc;
  logic [31:0]             m_rd;
  bit                      m_irq;
  bit                      m_vbd;

  int          checks = 0;
  int          passed = 0;
  logic [9:0]  vc_cur = 10'd100;
  logic [7:0]  fc0;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (readdata === m_rd) passed++;
    else $error("FAIL %s readdata: got %h expected %h", tag, readdata, m_rd);
    checks++;
    assert (gl_array === m_act) passed++;
    else $error("FAIL %s gl_array: got %h expected %h", tag, gl_array, m_act);
`ifdef SPRITE_IRQ_EN
    checks++;
    assert (irq === m_irq) passed++;
    else $error("FAIL %s irq: got %b expected %b", tag, irq, m_irq);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_sh[i] = '0;
    m_act  = '0;
    m_pend = 0;
    m_fc   = '0;
    m_rd   = '0;
    m_irq  = 0;
    m_vbd  = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; vga_vcount = vc_cur;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset");
  endtask

  // One bus cycle; the model is advanced by the written rules, then compared.
  task automatic step(input bit cs, input bit wr, input bit rd,
                      input logic [4:0] a, input logic [31:0] wd, input string tag);
    bit vb, vedge, commit, do_copy;
    chipselect = cs; write = wr; read = rd; address = a; writedata = wd;
    vga_vcount = vc_cur;
    vb      = (int'(vc_cur) >= VB);
    vedge   = vb && !m_vbd;
    commit  = cs && wr && (int'(a) == NS) && wd[0];
    do_copy = vedge && (m_pend || commit);
    if (cs && rd) begin
      if (int'(a) < NS)           m_rd = {8'h00, m_sh[a]};
      else if (int'(a) == NS + 1) m_rd = {16'h0000, m_fc, 7'b0, m_pend};
      else                        m_rd = '0;
    end
    if (do_copy)                                m_irq = 1;
    else if (cs && rd && (int'(a) == NS + 1))   m_irq = 0;
    if (do_copy) begin
      for (int i = 0; i < NS; i++) m_act[i] = m_sh[i];
      m_fc   = m_fc + 8'd1;
      m_pend = 0;
    end else if (commit) begin
      m_pend = 1;
    end
    if (cs && wr && (int'(a) < NS)) m_sh[a] = wd[EW-1:0];
    m_vbd = vb;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic bwr(input logic [4:0] a, input logic [31:0] d, input string tag);
    step(1, 1, 0, a, d, tag);
  endtask
  task automatic brd(input logic [4:0] a, input string tag);
    step(1, 0, 1, a, 32'h0, tag);
  endtask
  task automatic idle(input string tag);
    step(0, 0, 0, 5'd0, 32'h0, tag);
  endtask

  initial begin
    // Reset and read-back of every entry plus STATUS and an unmapped address
    vc_cur = 10'd100;
    do_reset();
    for (int i = 0; i < NS; i++) brd(5'(i), "rd_reset_entry");
    brd(5'd21, "rd_reset_status");
    chk32("status_after_reset", readdata, 32'h0);
    brd(5'd31, "rd_reset_unmapped");
    chk32("unmapped_zero", readdata, 32'h0);

    // Entry write lands in shadow only
    bwr(5'd3, 32'hFF0A_1234, "wr_e3");
    brd(5'd3, "rd_e3");
    chk32("e3_readback", readdata, 32'h000A_1234);
    chk32("gl3_untouched", 32'(gl_array[3]), 32'h0);

    // Commit then vblank edge
    bwr(5'd20, 32'h1, "ctrl_commit");
    brd(5'd21, "status_pending");
    chk32("status_pending", readdata, 32'h1);
    vc_cur = 10'd479; idle("vc479");
    vc_cur = 10'd480; idle("vc480_edge");
    chk32("gl3_committed", 32'(gl_array[3]), 32'h000A_1234);
    brd(5'd21, "status_after_commit");
    chk32("status_after_commit", readdata, 32'h0000_0100);

    // Commit while already in vblank waits for the next edge
    bwr(5'd3, 32'h0000_0042, "wr_e3_in_vb");
    bwr(5'd20, 32'h1, "commit_in_vb");
    repeat (3) idle("hold_in_vb");
    chk32("gl3_held", 32'(gl_array[3]), 32'h000A_1234);
    vc_cur = 10'd100; idle("leave_vb");
    vc_cur = 10'd480; idle("reenter_vb");
    chk32("gl3_after_reentry", 32'(gl_array[3]), 32'h0000_0042);

    // Entry write colliding with the copy cycle
    vc_cur = 10'd100;
    bwr(5'd5, 32'h111, "wr_e5_old");
    bwr(5'd20, 32'h1, "commit_old");
    vc_cur = 10'd480; idle("edge_old");
    vc_cur = 10'd100;
    bwr(5'd20, 32'h1, "commit_collide");
    vc_cur = 10'd480; bwr(5'd5, 32'h222, "wr_e5_on_edge");
    chk32("gl5_keeps_old", 32'(gl_array[5]), 32'h111);
    brd(5'd5, "rd_e5_new");
    chk32("shadow5_new", readdata, 32'h222);
    vc_cur = 10'd100;
    bwr(5'd20, 32'h1, "commit_new");
    vc_cur = 10'd480; idle("edge_new");
    chk32("gl5_propagated", 32'(gl_array[5]), 32'h222);

    // Commit request coincident with the vblank edge completes immediately
    vc_cur = 10'd100; idle("pre_coincident");
    vc_cur = 10'd480; bwr(5'd20, 32'h1, "commit_on_edge");
    brd(5'd21, "status_coincident");
    chk32("status_coincident", readdata, {16'h0, m_fc, 8'h00});

`ifdef SPRITE_IRQ_EN
    vc_cur = 10'd100;
    bwr(5'd20, 32'h1, "irq_commit");
    vc_cur = 10'd480; idle("irq_edge");
    chk32("irq_set", 32'(irq), 32'h1);
    brd(5'd21, "irq_status_rd");
    chk32("irq_cleared", 32'(irq), 32'h0);
`endif

    // Reset while pending aborts the commit
    vc_cur = 10'd100;
    bwr(5'd7, 32'h333, "wr_e7");
    bwr(5'd20, 32'h1, "commit_before_reset");
    do_reset();
    vc_cur = 10'd480; idle("edge_after_reset");
    chk32("gl7_aborted", 32'(gl_array[7]), 32'h0);

    // 256 commits wrap frame_cnt back to its start value
    fc0 = m_fc;
    for (int n = 0; n < 256; n++) begin
      vc_cur = 10'd100;
      bwr(5'd20, 32'h1, "wrap_commit");
      vc_cur = 10'd480; idle("wrap_edge");
    end
    brd(5'd21, "wrap_status");
    chk32("frame_cnt_wrap", readdata, {16'h0, fc0, 8'h00});

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] a;
      case ($urandom_range(0, 3))
        0: vc_cur = 10'd100;
        1: vc_cur = 10'd479;
        2: vc_cur = 10'd480;
        default: vc_cur = 10'd500;
      endcase
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        a = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 5) == 0) a = 5'd20;
        if ($urandom_range(0, 7) == 0) a = 5'd21;
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), a, $urandom, "random");
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
